video_axis_timing_counter: RTL and testbench
============================================

Name: video_axis_timing_counter

Overview:
- Parametrised single-axis video timing generator; the next generation of the fixed 629-line vertical counter.
- Counts one axis (horizontal pixels or vertical lines) through four phases: active, front porch, sync, back porch.
- Produces the position, blank and sync outputs, and a cascade carry.
- The VGA top instantiates it twice: horizontal with CE tied high, and vertical with CE driven by the horizontal CARRY_OUT.

Parameters:
- ACTIVE, 800, visible units per period (must be ≥1)
- FRONT_PORCH, 40, front-porch units (must be ≥1)
- SYNC_LEN, 128, sync-pulse units (must be ≥1)
- BACK_PORCH, 88, back-porch units (must be ≥1)
- SYNC_ACTIVE_HIGH, 0, 1 = SYNC_OUT is asserted high; 0 = asserted low
- WIDTH, 11, bit width of Q; 2**WIDTH must be > TOTAL-1, where TOTAL = ACTIVE+FRONT_PORCH+SYNC_LEN+BACK_PORCH

Ports:
- CLK_IN  input  1  system/pixel clock; all state changes on the rising edge
- ACTIVE_LOW_RESET  input  1  synchronous, active-low reset, sampled on the rising edge of CLK_IN
- CE  input  1  count enable; Q advances only on edges where CE=1
- Q  output  WIDTH  current position, 0..TOTAL-1
- ACTIVE_LOW_BLANK  output  1  0 whenever Q ≥ ACTIVE
- SYNC_OUT  output  1  sync pulse, polarity set by SYNC_ACTIVE_HIGH
- DISPLAY_EN  output  1  1 when Q < ACTIVE
- TERMINAL  output  1  1 when Q == TOTAL-1
- CARRY_OUT  output  1  combinational TERMINAL & CE; cascades into the next axis' CE

Behaviour:
- Clock and reset: one clock, CLK_IN, rising edge. Reset is synchronous, active-low (ACTIVE_LOW_RESET). No asynchronous paths.
- Values while ACTIVE_LOW_RESET=0 (after the edge):
  - Q=0, phase=ACT
  - ACTIVE_LOW_BLANK=1, DISPLAY_EN=1
  - SYNC_OUT = deasserted level (!SYNC_ACTIVE_HIGH)
  - TERMINAL=0
  - CARRY_OUT=0 while in reset
- Reset takes priority over CE and may arrive at any phase mid-count; the next edge with reset high and CE=1 gives Q=1.
- Counting:
  - CE=1 and Q==TOTAL-1 → Q=0 (wrap).
  - CE=1 otherwise → Q=Q+1.
  - CE=0 → all registers hold.
- Phase FSM (ACT → FP → SYN → BP → ACT), registered, advancing in step with Q:
  - ACT: Q in [0, ACTIVE-1]
  - FP: [ACTIVE, ACTIVE+FRONT_PORCH-1]
  - SYN: [ACTIVE+FRONT_PORCH, ACTIVE+FRONT_PORCH+SYNC_LEN-1]
  - BP: remainder up to TOTAL-1
  - Transitions are taken on the CE edge where Q reaches the last value of the current phase.
- Output registers: ACTIVE_LOW_BLANK, DISPLAY_EN, SYNC_OUT and TERMINAL are registered and decoded from next-state. They are therefore cycle-aligned with Q, with zero latency relative to Q.
  - ACTIVE_LOW_BLANK = 0 in FP, SYN and BP.
  - SYNC_OUT asserted only in SYN.
- CARRY_OUT is the only combinational output.
- Arithmetic: the increment is computed in WIDTH bits. The wrap compare is against the constant TOTAL-1, never against overflow.
- Parameter violation (any phase length 0, or TOTAL-1 ≥ 2**WIDTH): elaboration-time error.

Decomposition:
- Shared package video_timing_pkg holds:
  - the phase enum (ACT, FP, SYN, BP)
  - mode constant sets: SVGA 800x600@60 with H = 800/40/128/88 and V = 600/1/4/23; VGA 640x480@60 with H = 640/16/96/48 and V = 480/10/2/33
  - a TOTAL helper function
- No sub-module; the block is a single leaf.
- The top (video_timing_gen) cascades two instances.

Test Plan:
- Reset and wrap: params 4/2/3/1 (TOTAL=10), CE=1.
  - After reset: Q=0, ACTIVE_LOW_BLANK=1, SYNC_OUT=1.
  - Q runs 0..9 then 0.
  - TERMINAL=1 only at Q=9.
  - CARRY_OUT pulses 1 cycle per period.
- Phase decode, same params:
  - DISPLAY_EN=1 for Q 0..3.
  - ACTIVE_LOW_BLANK=0 for Q 4..9.
  - SYNC_OUT=0 for exactly Q 6..8.
  - Repeat with SYNC_ACTIVE_HIGH=1: SYNC_OUT=1 for Q 6..8, 0 elsewhere.
- CE gating: toggle CE 1,0,0,1 pseudo-randomly → Q advances only on CE=1 edges; outputs hold on CE=0; CARRY_OUT=0 when CE=0 even at Q=9.
- Reset mid-sync: deassert ACTIVE_LOW_RESET at Q=7.
  - Next edge: Q=0, SYNC_OUT deasserted, phase ACT.
  - Counting resumes at 1 on the first edge with reset released and CE=1.
- Cascade SVGA: H instance (800/40/128/88, CE=1) drives CARRY_OUT into V instance (600/1/4/23) CE.
  - V Q increments once per 1056 clocks.
  - V sync is asserted for V Q 601..604.
  - Frame wraps after 1056×628 clocks.

Source files
------------

// File: rtl/video_axis_timing_counter_pkg.sv
// rtl/video_axis_timing_counter_pkg.sv - shared phase enum, mode constants and period helper
// Contents:
//   phase_e       : ACT -> FP -> SYN -> BP counting phases of one axis
//   SVGA_* / VGA_*: per-axis active/front-porch/sync/back-porch lengths
//   timing_total  : period length of one axis
package video_timing_pkg;

  typedef enum logic [1:0] {
    ACT = 2'd0,
    FP  = 2'd1,
    SYN = 2'd2,
    BP  = 2'd3
  } phase_e;

  // SVGA 800x600@60
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

  // VGA 640x480@60
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync_len, input int bp);
    return active + fp + sync_len + bp;
  endfunction

endpackage

// File: rtl/video_axis_timing_counter_if.sv
// rtl/video_axis_timing_counter_if.sv - timing bundle of one counted axis
// Signals:
//   CE               : count enable into the counter
//   Q                : current position
//   ACTIVE_LOW_BLANK : 0 outside the active region
//   SYNC_OUT         : sync pulse, polarity chosen by the counter
//   DISPLAY_EN       : 1 inside the active region
//   TERMINAL         : 1 at the last position of the period
//   CARRY_OUT        : TERMINAL & CE, feeds the next axis' CE
// Modports: master = the counter, slave = the consumer / cascaded logic.
interface video_axis_timing_counter_if #(
  parameter int WIDTH = 11
);
  logic             CE;
  logic [WIDTH-1:0] Q;
  logic             ACTIVE_LOW_BLANK;
  logic             SYNC_OUT;
  logic             DISPLAY_EN;
  logic             TERMINAL;
  logic             CARRY_OUT;

  modport master (
    input  CE,
    output Q, ACTIVE_LOW_BLANK, SYNC_OUT, DISPLAY_EN, TERMINAL, CARRY_OUT
  );

  modport slave (
    output CE,
    input  Q, ACTIVE_LOW_BLANK, SYNC_OUT, DISPLAY_EN, TERMINAL, CARRY_OUT
  );
endinterface

// File: rtl/video_axis_timing_counter.sv
// rtl/video_axis_timing_counter.sv - single-axis video timing counter
// Ports:
//   CLK_IN           : clock, rising edge
//   ACTIVE_LOW_RESET : synchronous active-low reset
//   tmg (master)     : CE in; Q, ACTIVE_LOW_BLANK, SYNC_OUT, DISPLAY_EN,
//                      TERMINAL, CARRY_OUT out
module video_axis_timing_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE           = 800,
  parameter int FRONT_PORCH      = 40,
  parameter int SYNC_LEN         = 128,
  parameter int BACK_PORCH       = 88,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0,
  parameter int WIDTH            = 11
) (
  input  logic                        CLK_IN,
  input  logic                        ACTIVE_LOW_RESET,
  video_axis_timing_counter_if.master tmg
);

  localparam int TOTAL = timing_total(ACTIVE, FRONT_PORCH, SYNC_LEN, BACK_PORCH);

  // Last position of each phase; the phase moves on the CE edge leaving it.
  localparam logic [WIDTH-1:0] LAST_ACT = WIDTH'(ACTIVE - 1);
  localparam logic [WIDTH-1:0] LAST_FP  = WIDTH'(ACTIVE + FRONT_PORCH - 1);
  localparam logic [WIDTH-1:0] LAST_SYN = WIDTH'(ACTIVE + FRONT_PORCH + SYNC_LEN - 1);
  localparam logic [WIDTH-1:0] LAST_Q   = WIDTH'(TOTAL - 1);

  generate
    if ((ACTIVE < 1) || (FRONT_PORCH < 1) || (SYNC_LEN < 1) || (BACK_PORCH < 1) ||
        ((TOTAL - 1) >= 2 ** WIDTH)) begin : g_bad_params
      $error("video_axis_timing_counter: illegal phase lengths or WIDTH too small");
    end
  endgenerate

  logic [WIDTH-1:0] q_q, q_d;
  phase_e           phase_q, phase_d;
  logic             act_q, act_d;     // drives both blank (active-low) and display enable
  logic             sync_q, sync_d;
  logic             term_q, term_d;

  always_ff @(posedge CLK_IN) begin
    if (!ACTIVE_LOW_RESET) begin
      q_q     <= '0;
      phase_q <= ACT;
      act_q   <= 1'b1;
      sync_q  <= ~SYNC_ACTIVE_HIGH;
      term_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      phase_q <= phase_d;
      act_q   <= act_d;
      sync_q  <= sync_d;
      term_q  <= term_d;
    end
  end

  always_comb begin
    q_d     = q_q;
    phase_d = phase_q;
    act_d   = act_q;
    sync_d  = sync_q;
    term_d  = term_q;
    if (tmg.CE) begin
      // Wrap on the period constant, not on counter overflow.
      q_d = (q_q == LAST_Q) ? '0 : q_q + WIDTH'(1);
      case (phase_q)
        ACT:     if (q_q == LAST_ACT) phase_d = FP;
        FP:      if (q_q == LAST_FP)  phase_d = SYN;
        SYN:     if (q_q == LAST_SYN) phase_d = BP;
        BP:      if (q_q == LAST_Q)   phase_d = ACT;
        default: phase_d = ACT;
      endcase
      // Decoding from next state keeps the flags aligned with Q.
      act_d  = (phase_d == ACT);
      sync_d = (phase_d == SYN) ? SYNC_ACTIVE_HIGH : ~SYNC_ACTIVE_HIGH;
      term_d = (q_d == LAST_Q);
    end
  end

  assign tmg.Q                = q_q;
  assign tmg.ACTIVE_LOW_BLANK = act_q;
  assign tmg.DISPLAY_EN       = act_q;
  assign tmg.SYNC_OUT         = sync_q;
  assign tmg.TERMINAL         = term_q;
  assign tmg.CARRY_OUT        = term_q & tmg.CE;

endmodule

// File: tb/tb_video_axis_timing_counter.sv
// tb/tb_video_axis_timing_counter.sv - directed bench for the axis timing counter
module tb_video_axis_timing_counter;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   m_q = 0;   // expected Q of the 4/2/3/1 instances

  always #5 clk = ~clk;

  video_axis_timing_counter_if #(.WIDTH(4))  if0 ();
  video_axis_timing_counter_if #(.WIDTH(4))  if1 ();
  video_axis_timing_counter_if #(.WIDTH(11)) ifh ();
  video_axis_timing_counter_if #(.WIDTH(10)) ifv ();
  video_axis_timing_counter_if #(.WIDTH(4))  ifhs ();
  video_axis_timing_counter_if #(.WIDTH(10)) ifvs ();

  assign if0.CE  = ce;
  assign if1.CE  = ce;
  assign ifh.CE  = 1'b1;
  assign ifv.CE  = ifh.CARRY_OUT;
  assign ifhs.CE = 1'b1;
  assign ifvs.CE = ifhs.CARRY_OUT;

  video_axis_timing_counter #(.ACTIVE(4), .FRONT_PORCH(2), .SYNC_LEN(3), .BACK_PORCH(1),
    .SYNC_ACTIVE_HIGH(1'b0), .WIDTH(4)) u_lo (.CLK_IN(clk), .ACTIVE_LOW_RESET(rst_n), .tmg(if0));
  video_axis_timing_counter #(.ACTIVE(4), .FRONT_PORCH(2), .SYNC_LEN(3), .BACK_PORCH(1),
    .SYNC_ACTIVE_HIGH(1'b1), .WIDTH(4)) u_hi (.CLK_IN(clk), .ACTIVE_LOW_RESET(rst_n), .tmg(if1));
  video_axis_timing_counter #(.ACTIVE(SVGA_H_ACTIVE), .FRONT_PORCH(SVGA_H_FP), .SYNC_LEN(SVGA_H_SYNC),
    .BACK_PORCH(SVGA_H_BP), .SYNC_ACTIVE_HIGH(1'b0), .WIDTH(11)) u_h (.CLK_IN(clk), .ACTIVE_LOW_RESET(rst_n), .tmg(ifh));
  video_axis_timing_counter #(.ACTIVE(SVGA_V_ACTIVE), .FRONT_PORCH(SVGA_V_FP), .SYNC_LEN(SVGA_V_SYNC),
    .BACK_PORCH(SVGA_V_BP), .SYNC_ACTIVE_HIGH(1'b0), .WIDTH(10)) u_v (.CLK_IN(clk), .ACTIVE_LOW_RESET(rst_n), .tmg(ifv));
  video_axis_timing_counter #(.ACTIVE(4), .FRONT_PORCH(2), .SYNC_LEN(3), .BACK_PORCH(1),
    .SYNC_ACTIVE_HIGH(1'b0), .WIDTH(4)) u_hs (.CLK_IN(clk), .ACTIVE_LOW_RESET(rst_n), .tmg(ifhs));
  video_axis_timing_counter #(.ACTIVE(SVGA_V_ACTIVE), .FRONT_PORCH(SVGA_V_FP), .SYNC_LEN(SVGA_V_SYNC),
    .BACK_PORCH(SVGA_V_BP), .SYNC_ACTIVE_HIGH(1'b0), .WIDTH(10)) u_vs (.CLK_IN(clk), .ACTIVE_LOW_RESET(rst_n), .tmg(ifvs));

  // Advance one clock; called at a falling edge, returns at the next falling edge.
  task automatic tick();
    if (!rst_n) m_q = 0;
    else if (ce) m_q = (m_q == 9) ? 0 : m_q + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce = 1'b1;
    tick();
    tick();
    total++; if (if0.Q !== 4'd0) begin bad++; $display("FAIL reset_q got=%0d exp=0", if0.Q); end
    total++; if (if0.ACTIVE_LOW_BLANK !== 1'b1) begin bad++; $display("FAIL reset_blank got=%b exp=1", if0.ACTIVE_LOW_BLANK); end
    total++; if (if0.DISPLAY_EN !== 1'b1) begin bad++; $display("FAIL reset_disp got=%b exp=1", if0.DISPLAY_EN); end
    total++; if (if0.SYNC_OUT !== 1'b1) begin bad++; $display("FAIL reset_sync_lo got=%b exp=1", if0.SYNC_OUT); end
    total++; if (if1.SYNC_OUT !== 1'b0) begin bad++; $display("FAIL reset_sync_hi got=%b exp=0", if1.SYNC_OUT); end
    total++; if (if0.TERMINAL !== 1'b0) begin bad++; $display("FAIL reset_term got=%b exp=0", if0.TERMINAL); end
    total++; if (if0.CARRY_OUT !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", if0.CARRY_OUT); end
  endtask

  task automatic test_wrap();
    int carries;
    carries = 0;
    rst_n = 1'b1;
    ce = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++; if (if0.Q !== 4'(i % 10)) begin bad++; $display("FAIL wrap_q step=%0d got=%0d exp=%0d", i, if0.Q, i % 10); end
      total++; if (if0.TERMINAL !== ((i % 10) == 9)) begin bad++; $display("FAIL wrap_term q=%0d got=%b", i % 10, if0.TERMINAL); end
      if (if0.CARRY_OUT === 1'b1) carries++;
    end
    total++; if (carries !== 2) begin bad++; $display("FAIL wrap_carry_count got=%0d exp=2", carries); end
  endtask

  task automatic test_phase_decode();
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (if0.DISPLAY_EN !== (m_q < 4)) begin bad++; $display("FAIL dec_disp q=%0d got=%b", m_q, if0.DISPLAY_EN); end
      total++; if (if0.ACTIVE_LOW_BLANK !== (m_q < 4)) begin bad++; $display("FAIL dec_blank q=%0d got=%b", m_q, if0.ACTIVE_LOW_BLANK); end
      total++; if (if0.SYNC_OUT !== !(m_q >= 6 && m_q <= 8)) begin bad++; $display("FAIL dec_sync_lo q=%0d got=%b", m_q, if0.SYNC_OUT); end
      total++; if (if1.SYNC_OUT !== (m_q >= 6 && m_q <= 8)) begin bad++; $display("FAIL dec_sync_hi q=%0d got=%b", m_q, if1.SYNC_OUT); end
    end
  endtask

  task automatic test_ce_gating();
    logic [15:0] pat;
    pat = 16'b1011_0010_0111_0100;
    for (int i = 0; i < 16; i++) begin
      ce = pat[i];
      tick();
      total++; if (if0.Q !== 4'(m_q)) begin bad++; $display("FAIL ce_q step=%0d got=%0d exp=%0d", i, if0.Q, m_q); end
      total++; if (if0.SYNC_OUT !== !(m_q >= 6 && m_q <= 8)) begin bad++; $display("FAIL ce_sync step=%0d got=%b", i, if0.SYNC_OUT); end
      total++; if (if0.DISPLAY_EN !== (m_q < 4)) begin bad++; $display("FAIL ce_disp step=%0d got=%b", i, if0.DISPLAY_EN); end
    end
    ce = 1'b1;
    for (int n = 0; n < 10 && m_q != 9; n++) tick();
    ce = 1'b0;
    #1;
    total++; if (if0.TERMINAL !== 1'b1) begin bad++; $display("FAIL ce_term9 got=%b exp=1", if0.TERMINAL); end
    total++; if (if0.CARRY_OUT !== 1'b0) begin bad++; $display("FAIL ce_carry_off got=%b exp=0", if0.CARRY_OUT); end
    tick();
    total++; if (if0.Q !== 4'd9) begin bad++; $display("FAIL ce_hold9 got=%0d exp=9", if0.Q); end
    ce = 1'b1;
    #1;
    total++; if (if0.CARRY_OUT !== 1'b1) begin bad++; $display("FAIL ce_carry_on got=%b exp=1", if0.CARRY_OUT); end
    tick();
    total++; if (if0.Q !== 4'd0) begin bad++; $display("FAIL ce_wrap got=%0d exp=0", if0.Q); end
  endtask

  task automatic test_reset_mid_sync();
    ce = 1'b1;
    do_reset();
    for (int n = 0; n < 10 && m_q != 7; n++) tick();
    total++; if (if0.SYNC_OUT !== 1'b0) begin bad++; $display("FAIL mid_sync_lo got=%b exp=0", if0.SYNC_OUT); end
    total++; if (if1.SYNC_OUT !== 1'b1) begin bad++; $display("FAIL mid_sync_hi got=%b exp=1", if1.SYNC_OUT); end
    rst_n = 1'b0;
    tick();
    total++; if (if0.Q !== 4'd0) begin bad++; $display("FAIL mid_rst_q got=%0d exp=0", if0.Q); end
    total++; if (if0.SYNC_OUT !== 1'b1) begin bad++; $display("FAIL mid_rst_sync_lo got=%b exp=1", if0.SYNC_OUT); end
    total++; if (if1.SYNC_OUT !== 1'b0) begin bad++; $display("FAIL mid_rst_sync_hi got=%b exp=0", if1.SYNC_OUT); end
    total++; if (if0.DISPLAY_EN !== 1'b1) begin bad++; $display("FAIL mid_rst_disp got=%b exp=1", if0.DISPLAY_EN); end
    total++; if (if0.CARRY_OUT !== 1'b0) begin bad++; $display("FAIL mid_rst_carry got=%b exp=0", if0.CARRY_OUT); end
    rst_n = 1'b1;
    ce = 1'b0;
    tick();
    total++; if (if0.Q !== 4'd0) begin bad++; $display("FAIL mid_hold got=%0d exp=0", if0.Q); end
    ce = 1'b1;
    tick();
    total++; if (if0.Q !== 4'd1) begin bad++; $display("FAIL mid_resume got=%0d exp=1", if0.Q); end
    for (int n = 0; n < 3; n++) tick();
    total++; if (if0.ACTIVE_LOW_BLANK !== 1'b0 || if0.Q !== 4'd4) begin bad++; $display("FAIL mid_fp q=%0d blank=%b exp q=4 blank=0", if0.Q, if0.ACTIVE_LOW_BLANK); end
  endtask

  task automatic test_cascade_svga();
    do_reset();
    total++; if (ifh.Q !== 11'd0 || ifv.Q !== 10'd0) begin bad++; $display("FAIL svga_start h=%0d v=%0d exp 0/0", ifh.Q, ifv.Q); end
    for (int k = 1; k <= 3 * 1056; k++) begin
      tick();
      if (k == 839 || k == 840 || k == 967 || k == 968) begin
        total++; if (ifh.SYNC_OUT !== !(k >= 840 && k <= 967)) begin bad++; $display("FAIL svga_hsync h=%0d got=%b", k, ifh.SYNC_OUT); end
      end
      if ((k % 1056) == 1055 || (k % 1056) == 0) begin
        total++; if (ifh.Q !== 11'(k % 1056)) begin bad++; $display("FAIL svga_h k=%0d got=%0d exp=%0d", k, ifh.Q, k % 1056); end
        total++; if (ifv.Q !== 10'(k / 1056)) begin bad++; $display("FAIL svga_v k=%0d got=%0d exp=%0d", k, ifv.Q, k / 1056); end
        total++; if (ifh.CARRY_OUT !== ((k % 1056) == 1055)) begin bad++; $display("FAIL svga_carry k=%0d got=%b", k, ifh.CARRY_OUT); end
      end
    end
  endtask

  task automatic test_cascade_frame();
    int v;
    do_reset();
    for (int k = 1; k <= 6280; k++) begin
      tick();
      v = (k / 10) % 628;
      if (k == 6000 || k == 6010 || k == 6040 || k == 6050 || k == 6279 || k == 6280) begin
        total++; if (ifvs.Q !== 10'(v)) begin bad++; $display("FAIL frame_v k=%0d got=%0d exp=%0d", k, ifvs.Q, v); end
        total++; if (ifvs.SYNC_OUT !== !(v >= 601 && v <= 604)) begin bad++; $display("FAIL frame_vsync v=%0d got=%b", v, ifvs.SYNC_OUT); end
        total++; if (ifvs.DISPLAY_EN !== (v < 600)) begin bad++; $display("FAIL frame_disp v=%0d got=%b", v, ifvs.DISPLAY_EN); end
        total++; if (ifvs.TERMINAL !== (v == 627)) begin bad++; $display("FAIL frame_term v=%0d got=%b", v, ifvs.TERMINAL); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_wrap();
    test_phase_decode();
    test_ce_gating();
    test_reset_mid_sync();
    test_cascade_svga();
    test_cascade_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
